pixel_frame_writer: RTL and testbench

- Sink end of the pixel stream: captures the processed stream (pixel_out / pixel_valid) leaving the image pipeline.
- Packs 8-bit pixels into 32-bit little-endian words and writes them to memory through a valid/ready write port.
- A small word FIFO absorbs memory backpressure; the pixel stream has no backpressure, so overruns are flagged rather than stalled.

---
 rtl/pixel_frame_writer.sv | 254 +++++++++++++++++++++++++
 tb/tb_pixel_frame_writer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_writer.sv
`default_nettype none
// ============================================================================
// pixel_frame_writer : packs an 8-bit pixel stream into 32-bit little-endian
//                      words and writes them to memory over a valid/ready port.
// Option macro       : PIXEL_FRAME_WRITER_LINE_ALIGN_EN (each line starts a word)
// Revision           : 1.0
// ============================================================================
module pixel_frame_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       size_x,
  input  logic [11:0]       size_y,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        pixel_in,
  input  logic              pixel_in_valid,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int                 c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                 c_CNT_W      = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0]  c_ALIGN_MASK = ADDR_W'(3);
  localparam logic [ADDR_W-1:0]  c_WORD_BYTES = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Packer and frame bookkeeping
  logic [23:0]       r_cnt;
  logic [1:0]        r_lane;
  logic [31:0]       r_data;
  logic [3:0]        r_strb;
  logic [ADDR_W-1:0] r_addr;
  logic              r_overflow;

  // Word FIFO; the output registers always mirror the head entry
  logic [ADDR_W-1:0]  r_mem_addr [FIFO_DEPTH];
  logic [31:0]        r_mem_data [FIFO_DEPTH];
  logic [3:0]         r_mem_strb [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_wr_valid;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [31:0]        r_wr_data;
  logic [3:0]         r_wr_strb;

  logic [23:0]        w_total;
  logic               w_start_ok;
  logic               w_px;
  logic               w_last;
  logic               w_line_end;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_push_ok;
  logic               w_drop;
  logic               w_head_is_push;
  logic [31:0]        w_pk_data;
  logic [3:0]         w_pk_strb;
  logic [c_CNT_W-1:0] w_count_nxt;
  logic [c_PTR_W-1:0] w_rd_ptr_nxt;

  assign w_total    = {12'd0, size_x} * {12'd0, size_y};
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_px       = (r_state == S_CAPTURE) && pixel_in_valid;
  assign w_last     = (r_cnt == 24'd1);

`ifdef PIXEL_FRAME_WRITER_LINE_ALIGN_EN
  logic [11:0] r_size_x;
  logic [11:0] r_col;

  assign w_line_end = (r_col == (r_size_x - 12'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_size_x <= 12'd0;
      r_col    <= 12'd0;
    end else if (w_start_ok) begin
      r_size_x <= size_x;
      r_col    <= 12'd0;
    end else if (w_px) begin
      r_col <= w_line_end ? 12'd0 : (r_col + 12'd1);
    end
  end
`else
  assign w_line_end = 1'b0;
`endif

  assign w_push    = w_px && ((r_lane == 2'd3) || w_last || w_line_end);
  assign w_pop     = r_wr_valid && wr_ready;
  assign w_full    = (r_count == c_DEPTH);
  // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && !w_push_ok;

  always_comb begin
    w_pk_data                      = r_data;
    w_pk_data[{r_lane, 3'b000} +: 8] = pixel_in;
    w_pk_strb                      = r_strb | (4'b0001 << r_lane);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // True when the FIFO holds nothing beyond what leaves this cycle
  assign w_head_is_push = (r_count == '0) || ((r_count == c_CNT_W'(1)) && w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_total == 24'd0) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (w_px && w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_head_is_push) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- packer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 24'd0;
      r_lane     <= 2'd0;
      r_data     <= 32'd0;
      r_strb     <= 4'd0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt      <= w_total;
      r_lane     <= 2'd0;
      r_data     <= 32'd0;
      r_strb     <= 4'd0;
      r_addr     <= base_addr & ~c_ALIGN_MASK;
      r_overflow <= 1'b0;
    end else if (w_px) begin
      r_cnt <= r_cnt - 24'd1;
      if (w_push) begin
        // Dropped words still consume their address slot
        r_lane <= 2'd0;
        r_data <= 32'd0;
        r_strb <= 4'd0;
        r_addr <= r_addr + c_WORD_BYTES;
      end else begin
        r_lane <= r_lane + 2'd1;
        r_data <= w_pk_data;
        r_strb <= w_pk_strb;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop) begin
      w_count_nxt = r_count + c_CNT_W'(1);
    end else if (!w_push_ok && w_pop) begin
      w_count_nxt = r_count - c_CNT_W'(1);
    end
  end

  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_PTR_W'(1)) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_addr[r_wr_ptr] <= r_addr;
      r_mem_data[r_wr_ptr] <= w_pk_data;
      r_mem_strb[r_wr_ptr] <= w_pk_strb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 32'd0;
      r_wr_strb  <= 4'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_wr_valid <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        if (w_head_is_push) begin
          r_wr_addr <= r_addr;
          r_wr_data <= w_pk_data;
          r_wr_strb <= w_pk_strb;
        end else begin
          r_wr_addr <= r_mem_addr[w_rd_ptr_nxt];
          r_wr_data <= r_mem_data[w_rd_ptr_nxt];
          r_wr_strb <= r_mem_strb[w_rd_ptr_nxt];
        end
      end
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_strb  = r_wr_strb;
  assign busy     = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_writer.sv
`default_nettype none
// ============================================================================
// tb_pixel_frame_writer : randomized scoreboard bench for pixel_frame_writer.
// Revision              : 1.0
// ============================================================================
module tb_pixel_frame_writer;

  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [11:0]       size_x = 12'd0;
  logic [11:0]       size_y = 12'd0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        pixel_in = 8'd0;
  logic              pixel_in_valid = 1'b0;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              busy;
  logic              done;
  logic              overflow;

  pixel_frame_writer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .size_x        (size_x),
    .size_y        (size_y),
    .base_addr     (base_addr),
    .pixel_in      (pixel_in),
    .pixel_in_valid(pixel_in_valid),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] pix[$];
  int n_tests    = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int last_xfer  = -1;
  int done_cyc   = -1;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.strb = s;
    exp_q.push_back(w);
  endfunction

  // Reference: lay the frame's pixels out as memory words; keep only the first
  // max_words (what a stalled FIFO can hold).
  function automatic void model(input int sx, input int sy, input logic [31:0] base, input int max_words);
    logic [31:0] b;
    logic [31:0] d;
    logic [3:0]  s;
    int          nw;
    b  = base & ~32'h3;
    nw = 0;
`ifdef PIXEL_FRAME_WRITER_LINE_ALIGN_EN
    begin
      int wpl;
      wpl = (sx + 3) / 4;
      for (int y = 0; y < sy; y++) begin
        for (int wi = 0; wi < wpl; wi++) begin
          d = 32'd0;
          s = 4'd0;
          for (int k = 0; k < 4; k++) begin
            if (wi * 4 + k < sx) begin
              d[8*k +: 8] = pix[y * sx + wi * 4 + k];
              s[k]        = 1'b1;
            end
          end
          if (nw < max_words) exp_push(b + 32'((y * wpl + wi) * 4), d, s);
          nw++;
        end
      end
    end
`else
    for (int wi = 0; wi * 4 < sx * sy; wi++) begin
      d = 32'd0;
      s = 4'd0;
      for (int k = 0; k < 4; k++) begin
        if (wi * 4 + k < sx * sy) begin
          d[8*k +: 8] = pix[wi * 4 + k];
          s[k]        = 1'b1;
        end
      end
      if (nw < max_words) exp_push(b + 32'(wi * 4), d, s);
      nw++;
    end
`endif
  endfunction

  task automatic do_start(input int sx, input int sy, input logic [31:0] base);
    size_x    = 12'(sx);
    size_y    = 12'(sy);
    base_addr = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_pixels(input int pct, input bit glitch);
    if (glitch) begin
      size_x    = 12'd1;
      size_y    = 12'd1;
      base_addr = 32'hDEAD0000;
    end
    for (int i = 0; i < pix.size(); i++) begin
      while ($urandom_range(0, 99) >= pct) begin
        pixel_in_valid = 1'b0;
        pixel_in       = 8'h5A;
        @(posedge clk); #1;
      end
      pixel_in       = pix[i];
      pixel_in_valid = 1'b1;
      start          = glitch && (i == 1);
      @(posedge clk); #1;
      start          = 1'b0;
    end
    // Junk pixels after the frame must be ignored
    pixel_in       = 8'hA5;
    pixel_in_valid = 1'b1;
  endtask

  task automatic wait_done(input string name, input bit poke_start);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
    done_cyc = cyc;
    if (got) begin
      if (poke_start) begin
        size_x = 12'd4;
        size_y = 12'd1;
        start  = 1'b1;
      end
      @(negedge clk);
      check({name, "_done_one_cycle"}, 64'(done), 64'd0);
      if (poke_start) check({name, "_start_in_done_ignored"}, 64'(busy), 64'd0);
      start = 1'b0;
    end
    pixel_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = ($urandom_range(0, 99) < 70);
      default: wr_ready = 1'b0;
    endcase
  end

  // Monitor: every transfer pops one expected word
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst && wr_valid && wr_ready) begin
        last_xfer = cyc;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(wr_data), 64'(e.data));
          check("wr_strb", 64'(wr_strb), 64'(e.strb));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int sx, sy;
    logic [31:0] base;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_wr_addr",  64'(wr_addr),  64'd0);
    check("rst_wr_data",  64'(wr_data),  64'd0);
    check("rst_wr_strb",  64'(wr_strb),  64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Pixels while idle are ignored
    pixel_in       = 8'hEE;
    pixel_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pixel_in_valid = 1'b0;
    check("idle_pixels_busy", 64'(busy), 64'd0);

    // 4x2 frame, consecutive pixels
    ready_mode = 0;
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(8'(8'h10 + i));
    exp_push(32'h1000, 32'h13121110, 4'hF);
    exp_push(32'h1004, 32'h17161514, 4'hF);
    do_start(4, 2, 32'h1000);
    send_pixels(100, 1'b0);
    wait_done("t4x2", 1'b1);
    check("t4x2_done_latency", 64'(done_cyc - last_xfer), 64'd1);
    check("t4x2_overflow",     64'(overflow), 64'd0);
    check("t4x2_sb_empty",     64'(exp_q.size()), 64'd0);

    // 3x3 frame with gaps, random backpressure, start pulse mid-frame
    ready_mode = 1;
    pix.delete();
    for (int i = 1; i <= 9; i++) pix.push_back(8'(i));
`ifdef PIXEL_FRAME_WRITER_LINE_ALIGN_EN
    exp_push(32'h0, 32'h00030201, 4'h7);
    exp_push(32'h4, 32'h00060504, 4'h7);
    exp_push(32'h8, 32'h00090807, 4'h7);
`else
    exp_push(32'h0, 32'h04030201, 4'hF);
    exp_push(32'h4, 32'h08070605, 4'hF);
    exp_push(32'h8, 32'h00000009, 4'h1);
`endif
    do_start(3, 3, 32'h0);
    send_pixels(60, 1'b1);
    wait_done("t3x3", 1'b0);
    check("t3x3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      sx   = $urandom_range(1, 9);
      sy   = $urandom_range(1, 4);
      base = $urandom;
      pix.delete();
      for (int i = 0; i < sx * sy; i++) pix.push_back(8'($urandom));
      ready_mode = $urandom_range(0, 1);
      model(sx, sy, base, 1000);
      do_start(sx, sy, base);
      send_pixels($urandom_range(40, 100), 1'b0);
      wait_done("rand", 1'b0);
      check("rand_overflow", 64'(overflow), 64'd0);
      check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
    end

    // 16x4 frame into a stalled port: only FIFO_DEPTH words survive
    ready_mode = 2;
    @(posedge clk); #1;
    base = 32'h0000_8000;
    pix.delete();
    for (int i = 0; i < 64; i++) pix.push_back(8'($urandom));
    model(16, 4, base, FIFO_DEPTH);
    do_start(16, 4, base);
    send_pixels(100, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("ovf_set",      64'(overflow), 64'd1);
    check("ovf_busy",     64'(busy),     64'd1);
    check("ovf_wr_valid", 64'(wr_valid), 64'd1);
    ready_mode = 0;
    wait_done("ovf", 1'b0);
    check("ovf_sb_empty", 64'(exp_q.size()), 64'd0);
    check("ovf_sticky",   64'(overflow), 64'd1);
    pix.delete();
    for (int i = 0; i < 4; i++) pix.push_back(8'($urandom));
    model(2, 2, 32'h0000_9000, 1000);
    do_start(2, 2, 32'h0000_9000);
    check("ovf_cleared_by_start", 64'(overflow), 64'd0);
    send_pixels(100, 1'b0);
    wait_done("after_ovf", 1'b0);
    check("after_ovf_sb_empty", 64'(exp_q.size()), 64'd0);

    // Zero-size frame
    ready_mode = 0;
    do_start(0, 5, 32'h0000_A000);
    @(negedge clk);
    check("zero_done",     64'(done),     64'd1);
    check("zero_busy",     64'(busy),     64'd0);
    check("zero_wr_valid", 64'(wr_valid), 64'd0);
    @(negedge clk);
    check("zero_done_one_cycle", 64'(done), 64'd0);
    check("zero_busy_after",     64'(busy), 64'd0);
    @(posedge clk); #1;

    // Reset in the middle of capture with 3 words queued
    ready_mode = 2;
    @(posedge clk); #1;
    pix.delete();
    for (int i = 0; i < 32; i++) pix.push_back(8'($urandom));
    do_start(16, 2, 32'h0000_3000);
    for (int i = 0; i < 12; i++) begin
      pixel_in       = pix[i];
      pixel_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    pixel_in_valid = 1'b0;
    check("abort_pre_wr_valid", 64'(wr_valid), 64'd1);
    check("abort_pre_busy",     64'(busy),     64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_wr_valid", 64'(wr_valid), 64'd0);
    check("abort_busy",     64'(busy),     64'd0);
    check("abort_done",     64'(done),     64'd0);
    check("abort_wr_addr",  64'(wr_addr),  64'd0);
    @(posedge clk); #1;
    rst        = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    pix.delete();
    for (int i = 0; i < 4; i++) pix.push_back(8'($urandom));
    model(4, 1, 32'h0000_4000, 1000);
    do_start(4, 1, 32'h0000_4000);
    send_pixels(100, 1'b0);
    wait_done("post_abort", 1'b0);
    check("post_abort_sb_empty", 64'(exp_q.size()), 64'd0);
    check("post_abort_overflow", 64'(overflow), 64'd0);

    repeat (5) @(posedge clk);
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
